receptor_config_ctrl: RTL and testbench
=======================================

// Module: receptor_config_ctrl
// PURPOSE
//  Session controller for the 16-bit parity-checked serial receiver. On iniciar it
//  collects NUM_WORDS consecutive 16-bit words into a config bank. It retries a word
//  after a parity error or a timeout, and raises a sticky error once retries run out.
//  It sits between the top-level FSM and the receiver, and its cfg_dados bus drives
//  the system's configuration registers.
// PARAMETERS
//  NUM_WORDS       4      16-bit words per config session (>=1)
//  MAX_RETRIES     3      extra attempts per word after the first (attempts = MAX_RETRIES+1)
//  TIMEOUT_CYCLES  50000  clock cycles waited per attempt before declaring timeout (>=2)
// PORTS
//  clock        in   1               system clock, rising edge
//  reset_n      in   1               asynchronous, active-low reset
//  iniciar      in   1               start session (sampled only in OCIOSO)
//  abortar      in   1               abort session; priority over every other input
//  rx_pronto    in   1               receiver: word received, parity ok (1-cycle pulse)
//  rx_erro      in   1               receiver: parity error (1-cycle pulse)
//  rx_dado      in   16              receiver word, valid in the cycle rx_pronto=1
//  rx_habilita  out  1               level: receiver may accept a word
//  rx_limpa     out  1               1-cycle pulse: resync/clear receiver
//  cfg_dados    out  16*NUM_WORDS    word k at bits [16k+15:16k]
//  cfg_valido   out  1               all words loaded in the last session
//  ocupado      out  1               session in progress (state != OCIOSO)
//  erro         out  1               sticky: last session failed
//  indice       out  $clog2(NUM_WORDS) (min 1)  current word index
//  db_estado    out  3               current state encoding (debug)
// BEHAVIOUR
//  Reset: state=OCIOSO; cfg_dados=0, cfg_valido=0, erro=0, indice=0, retries=0,
//   timer=0; rx_habilita=0, rx_limpa=0. All outputs are registered or decoded from state.
//  States (3-bit):
//   OCIOSO   -> iniciar: clear cfg_valido, erro, indice, retries; go to LIMPA.
//   LIMPA    rx_limpa=1; timer<=0 -> ESPERA.
//   ESPERA   rx_habilita=1; timer++.
//            rx_erro -> ERRO_PAL.
//            else rx_pronto -> cfg_dados[indice]<=rx_dado on this edge, go to ARMAZENA.
//            else timer==TIMEOUT_CYCLES-1 -> ERRO_PAL.
//   ARMAZENA indice==NUM_WORDS-1 -> FIM.
//            else indice++, retries<=0, timer<=0 -> ESPERA (no rx_limpa between good words).
//   ERRO_PAL retries==MAX_RETRIES -> FALHA; else retries++ -> LIMPA (same indice).
//   FIM      cfg_valido<=1 -> OCIOSO.
//   FALHA    erro<=1 -> OCIOSO.
//  Latency: rx_pronto on the last word at edge t -> cfg_valido=1 after edge t+2.
//  Flags: cfg_valido and erro hold until the next accepted iniciar or abortar.
//  Simultaneous rx_pronto and rx_erro: treated as an error; the word is not stored.
//  rx_pronto/rx_erro outside ESPERA: ignored. iniciar outside OCIOSO: ignored.
//  abortar: in any state != OCIOSO, the next state is LIMPA-pulse-then-OCIOSO.
//   Implement this as a 1-cycle rx_limpa via the ABORTA path that reuses LIMPA's
//   output decode. cfg_valido<=0; erro is unchanged; stored words are retained but
//   are not valid. abortar in OCIOSO does nothing.
//  Timeout: an attempt lasts exactly TIMEOUT_CYCLES cycles in ESPERA. A timeout
//   counts as one retry, identical to a parity error.
//  Retries are counted per word and reset after each good word.
//  Async reset mid-session: immediate return to reset values; no rx_limpa is issued.
// STRUCTURE
//  Package receptor_pkg: state encodings (OCIOSO, LIMPA, ESPERA, ARMAZENA,
//   ERRO_PAL, FIM, FALHA), WORD_W=16.
//  Sub-module contador_timeout: parameter MAX; ports clock, reset_n, zera, conta;
//   output fim. It is reused later by the transmitter controller.
//  Everything else (FSM, index/retry counters, config bank) lives in this module.
// TESTING  (NUM_WORDS=4, MAX_RETRIES=3, TIMEOUT_CYCLES=20)
//  1. iniciar; pronto with 16'h1234, 16'hABCD, 16'h0F0F, 16'hBEEF
//     -> cfg_dados=64'hBEEF_0F0F_ABCD_1234, cfg_valido=1, erro=0, ocupado=0,
//     exactly one rx_limpa.
//  2. Word 1: rx_erro once, then pronto 16'h5555 -> word1=16'h5555, rx_limpa count=2,
//     session completes.
//  3. Word 0: four rx_erro pulses -> erro=1, cfg_valido=0, state OCIOSO after the 4th
//     error + 2 cycles.
//  4. No receiver activity -> 4 attempts x 20 cycles, then erro=1; rx_limpa pulses=4.
//  5. abortar after word 2 -> one rx_limpa, OCIOSO, cfg_valido=0; a new iniciar then
//     restarts at indice=0.
//  6. rx_pronto+rx_erro in the same cycle -> counted as an error, word not written;
//     iniciar while ocupado=1 -> no effect.

Source files
------------

// File: rtl/receptor_pkg.sv
// Shared definitions for the receiver-side session controller.
//   estado_t : 3-bit state encoding, exported on db_estado
//   WORD_W   : width of one receiver word
package receptor_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    LIMPA    = 3'd1,
    ESPERA   = 3'd2,
    ARMAZENA = 3'd3,
    ERRO_PAL = 3'd4,
    FIM      = 3'd5,
    FALHA    = 3'd6,
    ABORTA   = 3'd7
  } estado_t;

endpackage

// File: rtl/contador_timeout.sv
// Per-attempt timeout counter.
//   clock, reset_n : clock and asynchronous active-low reset
//   zera           : synchronous clear (priority over conta)
//   conta          : advance the count this cycle
//   fim            : count has reached MAX-1 (last cycle of the window)
// While conta is held, fim is high on exactly one cycle in every MAX cycles,
// so a window that starts from zero lasts exactly MAX cycles.
module contador_timeout #(
  parameter int MAX = 50000,
  localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (zera) begin
      count <= '0;
    end else if (conta) begin
      count <= fim ? '0 : count + 1'b1;
    end
  end

  assign fim = (count == LAST);

endmodule

// File: rtl/receptor_config_ctrl.sv
// Session controller between the top-level FSM and the 16-bit parity-checked
// serial receiver. A session loads NUM_WORDS words into a config bank,
// retrying a word after a parity error or timeout.
//   clock, reset_n       : clock, asynchronous active-low reset
//   iniciar              : start a session (only looked at while idle)
//   abortar              : abort the running session (highest priority)
//   rx_pronto/rx_erro    : receiver result pulses; rx_dado valid with rx_pronto
//   rx_habilita          : receiver may deliver a word
//   rx_limpa             : 1-cycle receiver resync pulse
//   cfg_dados            : config bank, word k at [16k+15:16k]
//   cfg_valido / erro    : last session completed / failed (held until next start)
//   ocupado              : a session is in progress
//   indice               : word currently being collected
//   db_estado            : current state encoding
//
// Receiver handshake: rx_habilita is high for every cycle the controller will
// accept a result; a single-cycle rx_pronto or rx_erro in such a cycle is
// consumed on that clock edge. Result pulses while rx_habilita is low are
// dropped. A cycle carrying both pulses counts as an error.
module receptor_config_ctrl
  import receptor_pkg::*;
#(
  parameter int NUM_WORDS      = 4,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        iniciar,
  input  logic                        abortar,
  input  logic                        rx_pronto,
  input  logic                        rx_erro,
  input  logic [WORD_W-1:0]           rx_dado,
  output logic                        rx_habilita,
  output logic                        rx_limpa,
  output logic [WORD_W*NUM_WORDS-1:0] cfg_dados,
  output logic                        cfg_valido,
  output logic                        ocupado,
  output logic                        erro,
  output logic [IDX_W-1:0]            indice,
  output logic [2:0]                  db_estado
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [RET_W-1:0] MAX_RET  = RET_W'(MAX_RETRIES);

  estado_t          state;
  logic [RET_W-1:0] retries;
  logic             timer_zera;
  logic             timer_conta;
  logic             timer_fim;

  // The attempt timer only runs in ESPERA and restarts from zero every time
  // ESPERA is entered (from LIMPA after a retry, or from ARMAZENA).
  assign timer_conta = (state == ESPERA);
  assign timer_zera  = (state != ESPERA);

  contador_timeout #(
    .MAX(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .zera   (timer_zera),
    .conta  (timer_conta),
    .fim    (timer_fim)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= OCIOSO;
      cfg_dados  <= '0;
      cfg_valido <= 1'b0;
      erro       <= 1'b0;
      indice     <= '0;
      retries    <= '0;
    end else if (abortar && state != OCIOSO && state != ABORTA) begin
      // Abort wins over everything; erro and the stored words are kept.
      state      <= ABORTA;
      cfg_valido <= 1'b0;
    end else begin
      case (state)
        OCIOSO: begin
          if (iniciar) begin
            cfg_valido <= 1'b0;
            erro       <= 1'b0;
            indice     <= '0;
            retries    <= '0;
            state      <= LIMPA;
          end
        end
        LIMPA: begin
          state <= ESPERA;
        end
        ESPERA: begin
          if (rx_erro) begin
            state <= ERRO_PAL;
          end else if (rx_pronto) begin
            cfg_dados[indice*WORD_W +: WORD_W] <= rx_dado;
            state <= ARMAZENA;
          end else if (timer_fim) begin
            state <= ERRO_PAL;
          end
        end
        ARMAZENA: begin
          if (indice == LAST_IDX) begin
            state <= FIM;
          end else begin
            // Receiver is already in sync after a good word: no resync pulse.
            indice  <= indice + 1'b1;
            retries <= '0;
            state   <= ESPERA;
          end
        end
        ERRO_PAL: begin
          if (retries == MAX_RET) begin
            state <= FALHA;
          end else begin
            retries <= retries + 1'b1;
            state   <= LIMPA;
          end
        end
        FIM: begin
          cfg_valido <= 1'b1;
          state      <= OCIOSO;
        end
        FALHA: begin
          erro  <= 1'b1;
          state <= OCIOSO;
        end
        ABORTA: begin
          state <= OCIOSO;
        end
        default: begin
          state <= OCIOSO;
        end
      endcase
    end
  end

  // ABORTA shares LIMPA's resync pulse so an aborted receiver is left clean.
  assign rx_limpa    = (state == LIMPA) || (state == ABORTA);
  assign rx_habilita = (state == ESPERA);
  assign ocupado     = (state != OCIOSO);
  assign db_estado   = state;

endmodule

// File: tb/tb_receptor_config_ctrl.sv
module tb_receptor_config_ctrl;
  import receptor_pkg::*;

  localparam int NW = 4;
  localparam int MR = 3;
  localparam int TO = 20;
  localparam int IW = 2;

  logic             clock, reset_n, iniciar, abortar, rx_pronto, rx_erro;
  logic [15:0]      rx_dado;
  logic             rx_habilita, rx_limpa, cfg_valido, ocupado, erro;
  logic [16*NW-1:0] cfg_dados;
  logic [IW-1:0]    indice;
  logic [2:0]       db_estado;

  receptor_config_ctrl #(
    .NUM_WORDS(NW), .MAX_RETRIES(MR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .abortar(abortar),
    .rx_pronto(rx_pronto), .rx_erro(rx_erro), .rx_dado(rx_dado),
    .rx_habilita(rx_habilita), .rx_limpa(rx_limpa), .cfg_dados(cfg_dados),
    .cfg_valido(cfg_valido), .ocupado(ocupado), .erro(erro),
    .indice(indice), .db_estado(db_estado)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // rx_limpa pulses observed since time zero
  int limpa_total = 0;
  always @(posedge clock) if (reset_n && rx_limpa) limpa_total <= limpa_total + 1;

  // ---------------- reference model ----------------
  // Session plan: per word, number of failed attempts before the good one
  // (more than MR means the word never succeeds), kind of each failure
  // (0 parity error, 1 pronto+erro together, 2 silence/timeout), the word data,
  // and an optional abort point (word index whose wait is aborted).
  logic [15:0] mbank [NW];
  bit          exp_valido, exp_erro;
  int          p_fails [NW];
  int          p_kind  [NW][MR+1];
  logic [15:0] p_data  [NW];
  int          p_abort;
  bit          p_busy_start;

  function automatic logic [63:0] pack_bank();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*16 +: 16] = mbank[k];
    return v;
  endfunction

  task automatic plan_clean();
    for (int k = 0; k < NW; k++) begin
      p_fails[k] = 0;
      p_data[k]  = 16'($urandom);
      for (int j = 0; j <= MR; j++) p_kind[k][j] = 0;
    end
    p_abort      = -1;
    p_busy_start = 1'b0;
  endtask

  task automatic plan_random();
    int r;
    plan_clean();
    for (int k = 0; k < NW; k++) begin
      r = $urandom_range(0, 9);
      p_fails[k] = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, MR) : MR + 1;
      for (int j = 0; j <= MR; j++) begin
        r = $urandom_range(0, 5);
        p_kind[k][j] = (r < 3) ? 0 : (r < 5) ? 1 : 2;
      end
    end
    p_abort      = ($urandom_range(0, 5) == 0) ? $urandom_range(0, NW-1) : -1;
    p_busy_start = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_habilita();
    int n = 0;
    while (!rx_habilita && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!rx_habilita) check("wait_habilita", {63'd0, rx_habilita}, 64'd1);
  endtask

  task automatic run_session(input string name);
    int base, retries_tot, w, a, d, cnt, last_w;
    bit failed, aborted, is_fail;
    base = limpa_total;
    retries_tot = 0;
    failed = 0;
    aborted = 0;
    last_w = NW - 1;

    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    check({name, "_ocupado_start"}, {63'd0, ocupado}, 64'd1);
    check({name, "_flags_cleared"}, {62'd0, cfg_valido, erro}, 64'd0);

    for (w = 0; w < NW && !failed && !aborted; w++) begin
      for (a = 0; ; a++) begin
        wait_habilita();
        if (a == 0) begin
          check({name, "_indice"}, {62'd0, indice}, 64'(w));
          if (p_abort == w) begin
            // abort together with a good-looking word: abort must win
            abortar = 1'b1; rx_pronto = 1'b1; rx_dado = 16'($urandom);
            @(negedge clock);
            abortar = 1'b0; rx_pronto = 1'b0;
            check({name, "_abort_limpa"}, {63'd0, rx_limpa}, 64'd1);
            @(negedge clock);
            aborted = 1;
            last_w = w;
            break;
          end
        end
        is_fail = (a < p_fails[w]);
        if (is_fail && p_kind[w][a] == 2) begin
          cnt = 0;
          while (rx_habilita && cnt < TO + 5) begin
            cnt++;
            @(negedge clock);
          end
          check({name, "_timeout_len"}, 64'(cnt), 64'(TO));
        end else begin
          d = $urandom_range(0, TO - 1);
          repeat (d) @(negedge clock);
          iniciar = p_busy_start;
          if (is_fail) begin
            rx_erro   = 1'b1;
            rx_pronto = (p_kind[w][a] == 1);
            rx_dado   = 16'($urandom);
          end else begin
            rx_pronto = 1'b1;
            rx_dado   = p_data[w];
          end
          @(negedge clock);
          rx_erro = 1'b0; rx_pronto = 1'b0; iniciar = 1'b0;
        end
        if (is_fail) begin
          if (a == MR) begin
            failed = 1;
            last_w = w;
            break;
          end
          retries_tot++;
        end else begin
          mbank[w] = p_data[w];
          break;
        end
      end
    end

    if (!aborted) begin
      // decisive edge was two edges ago at the next check point
      @(negedge clock);
      check({name, "_ocupado_before_end"}, {63'd0, ocupado}, 64'd1);
      check({name, "_valido_not_early"}, {63'd0, cfg_valido}, 64'd0);
      @(negedge clock);
    end
    exp_valido = !failed && !aborted;
    exp_erro   = failed;
    check({name, "_ocupado_end"}, {63'd0, ocupado}, 64'd0);
    check({name, "_estado_end"}, {61'd0, db_estado}, 64'(OCIOSO));
    check({name, "_valido"}, {63'd0, cfg_valido}, {63'd0, exp_valido});
    check({name, "_erro"}, {63'd0, erro}, {63'd0, exp_erro});
    check({name, "_dados"}, cfg_dados, pack_bank());
    check({name, "_indice_end"}, {62'd0, indice}, 64'(last_w));
    check({name, "_limpa_count"}, 64'(limpa_total - base),
          64'(1 + retries_tot + (aborted ? 1 : 0)));
  endtask

  // Activity while idle must be ignored.
  task automatic idle_noise();
    @(negedge clock);
    rx_pronto = 1'b1; rx_erro = 1'($urandom_range(0, 1));
    abortar = 1'b1; rx_dado = 16'($urandom);
    @(negedge clock);
    rx_pronto = 1'b0; rx_erro = 1'b0; abortar = 1'b0;
    @(negedge clock);
    check("idle_ocupado", {63'd0, ocupado}, 64'd0);
    check("idle_dados", cfg_dados, pack_bank());
    check("idle_flags", {62'd0, cfg_valido, erro}, {62'd0, exp_valido, exp_erro});
  endtask

  task automatic reset_mid_session();
    int base;
    plan_clean();
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    wait_habilita();
    rx_pronto = 1'b1; rx_dado = p_data[0];
    @(negedge clock); rx_pronto = 1'b0;
    wait_habilita();
    base = limpa_total;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_ocupado", {63'd0, ocupado}, 64'd0);
    check("rst_mid_dados", cfg_dados, 64'd0);
    check("rst_mid_flags", {62'd0, cfg_valido, erro}, 64'd0);
    check("rst_mid_indice", {62'd0, indice}, 64'd0);
    check("rst_mid_rx", {62'd0, rx_habilita, rx_limpa}, 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid_no_limpa", 64'(limpa_total - base), 64'd0);
    for (int k = 0; k < NW; k++) mbank[k] = '0;
    exp_valido = 1'b0;
    exp_erro   = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; iniciar = 1'b0; abortar = 1'b0;
    rx_pronto = 1'b0; rx_erro = 1'b0; rx_dado = '0;
    for (int k = 0; k < NW; k++) mbank[k] = '0;
    exp_valido = 1'b0;
    exp_erro   = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_dados", cfg_dados, 64'd0);
    check("rst_flags", {61'd0, cfg_valido, erro, ocupado}, 64'd0);
    check("rst_indice", {62'd0, indice}, 64'd0);
    check("rst_estado", {61'd0, db_estado}, 64'(OCIOSO));
    check("rst_rx", {62'd0, rx_habilita, rx_limpa}, 64'd0);
    reset_n = 1'b1;

    // clean session with fixed words
    plan_clean();
    p_data[0] = 16'h1234; p_data[1] = 16'hABCD; p_data[2] = 16'h0F0F; p_data[3] = 16'hBEEF;
    run_session("s1");
    check("s1_bank_literal", cfg_dados, 64'hBEEF_0F0F_ABCD_1234);

    // one parity error on word 1
    plan_clean();
    p_fails[1] = 1; p_data[1] = 16'h5555;
    run_session("s2");
    check("s2_word1", {48'd0, cfg_dados[31:16]}, 64'h5555);

    idle_noise();

    // word 0 fails four times by parity
    plan_clean();
    p_fails[0] = MR + 1;
    run_session("s3");

    // word 0 never answered: four timeouts
    plan_clean();
    p_fails[0] = MR + 1;
    for (int j = 0; j <= MR; j++) p_kind[0][j] = 2;
    run_session("s4");

    // abort after two words, then a fresh session
    plan_clean();
    p_abort = 2;
    run_session("s5");
    idle_noise();
    plan_clean();
    run_session("s5b");

    // simultaneous pronto+erro, and iniciar while busy
    plan_clean();
    p_fails[2] = 1; p_kind[2][0] = 1; p_busy_start = 1'b1;
    run_session("s6");

    reset_mid_session();

    for (int s = 0; s < 12; s++) begin
      plan_random();
      run_session($sformatf("r%0d", s));
      if (s % 4 == 3) idle_noise();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
